// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: 1 bit per cycle shift-add multiply and restoring divide.
// Optional RV64 *W word ops are built when MULDIV_WORD_OPS_EN is defined.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        wordOp,
  input  logic [63:0] rs1Data,
  input  logic [63:0] rs2Data,
  input  logic [4:0]  rdAddr,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic [4:0]  resultAddr
);
  localparam int unsigned XLEN = 64;
  localparam int unsigned CW   = 7;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic            word_q;
  logic            neg_q;
  logic            special_q;
  logic [XLEN-1:0] acc_hi, acc_lo, opb;

  logic            is_mulh, word_eff, a_signed, b_signed, sa, sb, neg, div0, ovf;
  logic [XLEN-1:0] a_eff, b_eff, min_neg, mag_a, mag_b, special_val;

  assign is_mulh = ~op[2] && (op[1:0] != 2'b00);

`ifdef MULDIV_WORD_OPS_EN
  assign word_eff = wordOp & ~is_mulh;
`else
  logic unused_word_op;
  assign unused_word_op = wordOp;
  assign word_eff = 1'b0;
`endif

  // Operand conditioning at accept: extension, magnitudes, sign and special-case detection
  always_comb begin
    a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_eff    = rs1Data;
    b_eff    = rs2Data;
    min_neg  = {1'b1, 63'b0};
`ifdef MULDIV_WORD_OPS_EN
    if (word_eff) begin
      a_eff   = a_signed ? {{32{rs1Data[31]}}, rs1Data[31:0]} : {32'b0, rs1Data[31:0]};
      b_eff   = b_signed ? {{32{rs2Data[31]}}, rs2Data[31:0]} : {32'b0, rs2Data[31:0]};
      min_neg = {{33{1'b1}}, 31'b0};
    end
`endif
    sa          = a_signed & a_eff[XLEN-1];
    sb          = b_signed & b_eff[XLEN-1];
    mag_a       = sa ? (XLEN'(0) - a_eff) : a_eff;
    mag_b       = sb ? (XLEN'(0) - b_eff) : b_eff;
    neg         = (op[2] & op[1]) ? sa : (sa ^ sb);
    div0        = op[2] && (b_eff == '0);
    ovf         = op[2] && !op[0] && (a_eff == min_neg) && (b_eff == '1);
    special_val = div0 ? (op[1] ? a_eff : '1) : (op[1] ? '0 : a_eff);
  end

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_rs;
  logic [XLEN+1:0] div_diff;
  logic            div_ge;

  // One iteration of the multiply (shift right) or divide (shift left) recurrence
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    div_rs   = {acc_hi, acc_lo[XLEN-1]};
    div_diff = {1'b0, div_rs} - {2'b0, opb};
    div_ge   = ~div_diff[XLEN+1];
  end

  logic [2*XLEN-1:0] prod_n;
  logic [XLEN-1:0]   val, fin;

  always_comb begin
    prod_n = neg_q ? ((2*XLEN)'(0) - {acc_hi, acc_lo}) : {acc_hi, acc_lo};
    if (special_q)          val = acc_lo;
    else if (op_q == 3'b000) val = word_q ? {32'b0, acc_lo[63:32]} : acc_lo;
    else if (!op_q[2])       val = prod_n[2*XLEN-1:XLEN];
    else if (!op_q[1])       val = neg_q ? (XLEN'(0) - acc_lo) : acc_lo;
    else                     val = neg_q ? (XLEN'(0) - acc_hi) : acc_hi;
    fin = word_q ? {{32{val[31]}}, val[31:0]} : val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= '0;
      word_q     <= 1'b0;
      neg_q      <= 1'b0;
      special_q  <= 1'b0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      opb        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      resultAddr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            op_q       <= op;
            word_q     <= word_eff;
            neg_q      <= neg;
            resultAddr <= rdAddr;
            busy       <= 1'b1;
            acc_hi     <= '0;
            if (div0 || ovf) begin
              // Special cases spend two cycles in FIX so done lands after E0+2
              special_q <= 1'b1;
              acc_lo    <= special_val;
              cnt       <= CW'(1);
              state     <= FIX;
            end else begin
              special_q <= 1'b0;
              cnt       <= word_eff ? CW'(32) : CW'(64);
              state     <= RUN;
              if (op[2]) begin
                acc_lo <= word_eff ? {mag_a[31:0], 32'b0} : mag_a;
                opb    <= mag_b;
              end else begin
                acc_lo <= mag_b;
                opb    <= mag_a;
              end
            end
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
          if (op_q[2]) begin
            acc_hi <= div_ge ? div_diff[XLEN-1:0] : div_rs[XLEN-1:0];
            acc_lo <= {acc_lo[XLEN-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[XLEN:1];
            acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
          end
        end
        FIX: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            result <= fin;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (word-op vectors enabled by MULDIV_WORD_OPS_EN).
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        wordOp;
  logic [63:0] rs1Data, rs2Data;
  logic [4:0]  rdAddr;
  logic        busy, done;
  logic [63:0] result;
  logic [4:0]  resultAddr;

  int checks = 0;
  int failures = 0;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
  localparam int LAT_FULL = 65;
  localparam int LAT_WORD = 33;
  localparam int LAT_SPEC = 2;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .wordOp(wordOp),
    .rs1Data(rs1Data), .rs2Data(rs2Data), .rdAddr(rdAddr),
    .busy(busy), .done(done), .result(result), .resultAddr(resultAddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op at the next negedge; lat counts edges after the accepting edge E0 until done
  task automatic run_op(input string tag, input logic [2:0] o, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                        input logic [63:0] exp, input int exp_lat);
    int lat;
    int bcnt;
    bit got;
    @(negedge clk);
    op = o; wordOp = w; rs1Data = a; rs2Data = b; rdAddr = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_accept_busy"}, 64'(busy), 64'(1));
    chk({tag, "_accept_done"}, 64'(done), 64'(0));
    lat = 0; bcnt = 0; got = 1'b0;
    while (!got && lat < 200) begin
      if (busy) bcnt++;
      if (done) got = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    chk({tag, "_done_seen"}, 64'(got), 64'(1));
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat));
    chk({tag, "_result"}, result, exp);
    chk({tag, "_addr"}, 64'(resultAddr), 64'(rd));
  endtask

  initial begin
    int pulses;
    reset = 1'b1; start = 1'b0; op = '0; wordOp = 1'b0;
    rs1Data = '0; rs2Data = '0; rdAddr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_result", result, 64'(0));
    chk("rst_addr", 64'(resultAddr), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    run_op("mul", MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, LAT_FULL);
    run_op("mulhu", MULHU, 1'b0, '1, '1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, LAT_FULL);
    run_op("mulh", MULH, 1'b0, '1, '1, 5'd7, 64'h0, LAT_FULL);
    run_op("mulhsu", MULHSU, 1'b0, '1, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, LAT_FULL);
    run_op("div", DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFD, LAT_FULL);
    run_op("rem", REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, LAT_FULL);
    run_op("divu", DIVU, 1'b0, 64'd100, 64'd7, 5'd11, 64'd14, LAT_FULL);
    run_op("remu", REMU, 1'b0, 64'd100, 64'd7, 5'd12, 64'd2, LAT_FULL);
    run_op("divu_by0", DIVU, 1'b0, 64'd9, 64'd0, 5'd13, '1, LAT_SPEC);
    run_op("rem_by0", REM, 1'b0, 64'd5, 64'd0, 5'd14, 64'd5, LAT_SPEC);
    run_op("div_ovf", DIV, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd15, 64'h8000_0000_0000_0000, LAT_SPEC);
    run_op("rem_ovf", REM, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd16, 64'h0, LAT_SPEC);

    // Abandon a DIV with reset ten cycles in
    @(negedge clk);
    op = DIV; wordOp = 1'b0; rs1Data = 64'd1000; rs2Data = 64'd3; rdAddr = 5'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_result", result, 64'(0));
    chk("abort_addr", 64'(resultAddr), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'(0));

    run_op("mul_3x4", MUL, 1'b0, 64'd3, 64'd4, 5'd21, 64'd12, LAT_FULL);
    run_op("b2b_divu", DIVU, 1'b0, 64'd8, 64'd2, 5'd22, 64'd4, LAT_FULL);

`ifdef MULDIV_WORD_OPS_EN
    run_op("mulw", MUL, 1'b1, 64'h4000_0000, 64'd2, 5'd23, 64'hFFFF_FFFF_8000_0000, LAT_WORD);
    run_op("divuw", DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 5'd24, 64'h0000_0000_7FFF_FFFF, LAT_WORD);
`else
    run_op("mulw_off", MUL, 1'b1, 64'h4000_0000, 64'd2, 5'd23, 64'h0000_0000_8000_0000, LAT_FULL);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
